sh4_fpu_fadd_pipe: RTL
======================

// Module: sh4_fpu_fadd_pipe
// PURPOSE
//  Pipelined, parametrised FADD/FSUB unit for the SH4 FPU on unpacked operands.
//  Three register stages: align, add, normalise/special-case.
//  Adds FSUB mode, valid/ready backpressure, flush, correct Inf/NaN/zero results and an inexact flag.
//  Sits between the FPU unpack stage and the shared round/pack stage.
// PARAMETERS
//  EXP_W   10  input exponent width; unpack bias applies (1.0 = exp 127 single)
//  FRAC_W  25  input fraction width; hidden 1 not included
//  TAG_W   5   writeback tag width, carried unchanged
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous, active-high reset
//  flush      in   1          kill all in-flight ops (exception/branch squash)
//  ven        in   1          enable invalid-operation exception reporting
//  i_valid    in   1          input op valid
//  i_ready    out  1          unit accepts input this cycle
//  i_sub      in   1          1 = a-b (b_sign inverted), 0 = a+b
//  i_tag      in   TAG_W      op tag
//  a_sign/b_sign        in  1       operand signs
//  a_exp/b_exp          in  EXP_W   operand exponents
//  a_frac/b_frac        in  FRAC_W  operand fractions
//  a_is_zero/inf/nan, b_is_zero/inf/nan  in  1  operand class flags
//  o_valid    out  1          result valid
//  o_ready    in   1          downstream accepts result
//  o_tag      out  TAG_W      tag of result
//  o_sign     out  1          result sign
//  o_exp      out  EXP_W+1    result exponent, pre-round, may be out of range
//  o_frac     out  FRAC_W     normalised fraction, hidden 1 dropped
//  o_is_zero/o_is_inf/o_is_nan  out 1  result class
//  o_inexact  out  1          bits lost in alignment/normalisation (sticky)
//  invalid    out  1          invalid-op exception (qualified by ven, o_valid)
// BEHAVIOUR
//  Reset: all stage valid bits 0; o_valid=0, invalid=0, o_inexact=0; datapath regs 0.
//  Latency: exactly 3 cycles from accept to o_valid with no stall. Throughput 1/cycle.
//  Handshake: stage k advances when its successor is empty or advancing.
//   Stage 3 advances when o_ready=1. i_ready = !s1_valid | s1_advance.
//   Accept when i_valid & i_ready. Output holds stable while o_valid & !o_ready.
//  flush: clears all stage valid bits next edge. Input presented the same cycle is dropped.
//   rst and flush win over simultaneous accept.
//  S1 align: eb_sign = b_sign ^ i_sub; diff = a_exp-b_exp (signed EXP_W+1).
//   Swap so larger magnitude is A: larger exp, or equal exp with larger frac.
//   Shift B right by |diff| with sticky collect. Shifts >= FRAC_W+3 give all-zero + sticky.
//  S2 add: FRAC_W+3 bit magnitude add (same sign) or subtract (differing sign).
//   Operands carry hidden 1, guard and sticky bits.
//  S3 normalise: CLZ, left shift, o_exp = exp_A + 1 - clz. o_inexact = any discarded bit.
//  Special-case priority, highest first:
//   1 any NaN -> o_is_nan=1, sign/frac of first NaN operand, quieted.
//   2 Inf-Inf (eff. opposite signs) -> o_is_nan=1 (default qNaN), invalid.
//   3 one or both Inf -> o_is_inf=1, sign of the Inf.
//   4 both zero -> zero; sign = a_sign & eb_sign (RN rule).
//   5 one zero -> other operand passed through exactly.
//   6 exact cancellation -> +0, o_is_zero=1.
//  invalid = ven & (sNaN operand (frac[FRAC_W-3]=1) | Inf-Inf case); asserted with o_valid.
//  Class flags mutually exclusive at output.
// TESTING
//  1.0+1.0 (exp127,frac0 each), i_sub=0 -> 3 cycles later exp128, frac0, zero/inf/nan=0.
//  1.5-1.5, i_sub=1 -> o_is_zero=1, o_sign=0, o_inexact=0.
//  +Inf + -Inf, ven=1 -> o_is_nan=1, invalid=1. Same with ven=0 -> invalid=0.
//  1.0 + 2^-30 -> result 1.0, o_inexact=1. Tests the shift-beyond-width sticky path.
//  Back-to-back ops, o_ready low 4 cycles mid-stream -> no loss/duplication, tags in order, i_ready low after pipe fills.
//  Flush with 3 ops in flight plus new i_valid -> no o_valid afterwards. Next op emerges after 3 cycles.

Source files
------------

// File: rtl/sh4_fpu_fadd_pipe.sv
// SH4 FPU FADD/FSUB on unpacked operands: align -> add -> normalise/special-case,
// three register stages with valid/ready backpressure and flush.
module sh4_fpu_fadd_pipe #(
    parameter int EXP_W  = 10,
    parameter int FRAC_W = 25,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ven,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic              i_sub,
    input  logic [TAG_W-1:0]  i_tag,
    input  logic              a_sign,
    input  logic              b_sign,
    input  logic [EXP_W-1:0]  a_exp,
    input  logic [EXP_W-1:0]  b_exp,
    input  logic [FRAC_W-1:0] a_frac,
    input  logic [FRAC_W-1:0] b_frac,
    input  logic              a_is_zero,
    input  logic              a_is_inf,
    input  logic              a_is_nan,
    input  logic              b_is_zero,
    input  logic              b_is_inf,
    input  logic              b_is_nan,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_sign,
    output logic [EXP_W:0]    o_exp,
    output logic [FRAC_W-1:0] o_frac,
    output logic              o_is_zero,
    output logic              o_is_inf,
    output logic              o_is_nan,
    output logic              o_inexact,
    output logic              invalid
);

    // Mantissa layout: hidden 1, fraction, guard, sticky.
    localparam int W     = FRAC_W + 3;
    localparam int CLZ_W = $clog2(W + 2);
    localparam logic [FRAC_W-1:0] SNAN_BIT     = FRAC_W'(1) << (FRAC_W - 3);
    localparam logic [FRAC_W-1:0] DEF_NAN_FRAC = ~SNAN_BIT;
    localparam logic [EXP_W:0]    EXP_MAX      = {1'b0, {EXP_W{1'b1}}};

    typedef struct packed {
        logic              en;
        logic              sign;
        logic [EXP_W:0]    exp;
        logic [FRAC_W-1:0] frac;
        logic              zero;
        logic              inf;
        logic              nan;
        logic              invalid;
    } spec_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic             sub;
        logic [W-1:0]     ma;
        logic [W-1:0]     mb;
        spec_t            spec;
    } s1_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [W:0]       sum;
        spec_t            spec;
    } s2_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic              sign;
        logic [EXP_W:0]    exp;
        logic [FRAC_W-1:0] frac;
        logic              zero;
        logic              inf;
        logic              nan;
        logic              inexact;
        logic              invalid;
    } s3_t;

    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s3_valid_q, s3_valid_d;
    s1_t  s1_q, s1_d, s1_new;
    s2_t  s2_q, s2_d, s2_new;
    s3_t  s3_q, s3_d, s3_new;

    logic en1, en2, en3, accept;

    logic              eb_sign, a_big, infinf, a_snan, b_snan, lost;
    logic [EXP_W-1:0]  big_exp, sml_exp, dabs;
    logic [FRAC_W-1:0] big_frac, sml_frac;
    logic [W-1:0]      mb_raw, mb_sh;
    spec_t             sp;
    logic [CLZ_W-1:0]  clz;
    logic [W:0]        sum_n;

    // A stage may load when it is empty or its content is moving on.
    always_comb begin
        en3    = !s3_valid_q | o_ready;
        en2    = !s2_valid_q | en3;
        en1    = !s1_valid_q | en2;
        accept = i_valid & en1;

        s1_valid_d = en1 ? accept     : s1_valid_q;
        s2_valid_d = en2 ? s1_valid_q : s2_valid_q;
        s3_valid_d = en3 ? s2_valid_q : s3_valid_q;
        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
            s3_valid_d = 1'b0;
        end
    end

    always_comb begin
        eb_sign  = b_sign ^ i_sub;
        a_big    = (a_exp > b_exp) | ((a_exp == b_exp) & (a_frac >= b_frac));
        big_exp  = a_big ? a_exp  : b_exp;
        sml_exp  = a_big ? b_exp  : a_exp;
        big_frac = a_big ? a_frac : b_frac;
        sml_frac = a_big ? b_frac : a_frac;
        dabs     = big_exp - sml_exp;
        mb_raw   = {1'b1, sml_frac, 2'b00};
        mb_sh    = mb_raw >> dabs;
        lost     = |(mb_raw & ~({W{1'b1}} << dabs));

        a_snan = a_is_nan & a_frac[FRAC_W-3];
        b_snan = b_is_nan & b_frac[FRAC_W-3];
        infinf = a_is_inf & b_is_inf & (a_sign ^ eb_sign);

        sp         = '0;
        sp.invalid = ven & (a_snan | b_snan | infinf);
        if (a_is_nan | b_is_nan) begin
            sp.en   = 1'b1;
            sp.nan  = 1'b1;
            sp.sign = a_is_nan ? a_sign : b_sign;
            sp.exp  = EXP_MAX;
            sp.frac = (a_is_nan ? a_frac : b_frac) & ~SNAN_BIT;
        end else if (infinf) begin
            sp.en   = 1'b1;
            sp.nan  = 1'b1;
            sp.exp  = EXP_MAX;
            sp.frac = DEF_NAN_FRAC;
        end else if (a_is_inf | b_is_inf) begin
            sp.en   = 1'b1;
            sp.inf  = 1'b1;
            sp.sign = a_is_inf ? a_sign : eb_sign;
            sp.exp  = EXP_MAX;
        end else if (a_is_zero & b_is_zero) begin
            sp.en   = 1'b1;
            sp.zero = 1'b1;
            sp.sign = a_sign & eb_sign;
        end else if (a_is_zero) begin
            sp.en   = 1'b1;
            sp.sign = eb_sign;
            sp.exp  = {1'b0, b_exp};
            sp.frac = b_frac;
        end else if (b_is_zero) begin
            sp.en   = 1'b1;
            sp.sign = a_sign;
            sp.exp  = {1'b0, a_exp};
            sp.frac = a_frac;
        end

        s1_new.tag  = i_tag;
        s1_new.sign = a_big ? a_sign : eb_sign;
        s1_new.exp  = big_exp;
        s1_new.sub  = a_sign ^ eb_sign;
        s1_new.ma   = {1'b1, big_frac, 2'b00};
        s1_new.mb   = {mb_sh[W-1:1], mb_sh[0] | lost};
        s1_new.spec = sp;

        s1_d = en1 ? s1_new : s1_q;
    end

    // Swap guarantees ma >= mb, so the subtract never goes negative.
    always_comb begin
        s2_new.tag  = s1_q.tag;
        s2_new.sign = s1_q.sign;
        s2_new.exp  = s1_q.exp;
        s2_new.spec = s1_q.spec;
        s2_new.sum  = s1_q.sub ? ({1'b0, s1_q.ma} - {1'b0, s1_q.mb})
                               : ({1'b0, s1_q.ma} + {1'b0, s1_q.mb});
        s2_d = en2 ? s2_new : s2_q;
    end

    always_comb begin
        clz = CLZ_W'(W + 1);
        for (int i = 0; i <= W; i++) begin
            if (s2_q.sum[i]) clz = CLZ_W'(W - i);
        end
        sum_n = s2_q.sum << clz;

        s3_new         = '0;
        s3_new.tag     = s2_q.tag;
        s3_new.invalid = s2_q.spec.invalid;
        if (s2_q.spec.en) begin
            s3_new.sign = s2_q.spec.sign;
            s3_new.exp  = s2_q.spec.exp;
            s3_new.frac = s2_q.spec.frac;
            s3_new.zero = s2_q.spec.zero;
            s3_new.inf  = s2_q.spec.inf;
            s3_new.nan  = s2_q.spec.nan;
        end else if (!sum_n[W]) begin
            s3_new.zero = 1'b1;
        end else begin
            s3_new.sign    = s2_q.sign;
            s3_new.exp     = {1'b0, s2_q.exp} + (EXP_W+1)'(1) - (EXP_W+1)'(clz);
            s3_new.frac    = sum_n[W-1 -: FRAC_W];
            s3_new.inexact = |sum_n[W-FRAC_W-1:0];
        end

        s3_d = en3 ? s3_new : s3_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
        end
    end

    assign i_ready   = en1;
    assign o_valid   = s3_valid_q;
    assign o_tag     = s3_q.tag;
    assign o_sign    = s3_q.sign;
    assign o_exp     = s3_q.exp;
    assign o_frac    = s3_q.frac;
    assign o_is_zero = s3_q.zero;
    assign o_is_inf  = s3_q.inf;
    assign o_is_nan  = s3_q.nan;
    assign o_inexact = s3_q.inexact;
    assign invalid   = s3_q.invalid & s3_valid_q;

endmodule
